// File: rtl/seven_seg_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared types and constants for the eight-digit seven-segment scan controller.
//   NUM_DIGITS  : number of multiplexed digits on the display
//   digit_idx_t : index of the currently scanned digit
//   nibble_t    : one hex digit of the displayed value
//   seg_t       : segment vector {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [2:0] digit_idx_t;
    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_bto7s.sv
// -----------------------------------------------------------------------------
// bto7s
// Binary-to-seven-segment hex decoder, purely combinational.
//   x_in  [3:0] : hex digit to decode
//   s_out [6:0] : segments {g,f,e,d,c,b,a}, active-high (1 = segment on)
// -----------------------------------------------------------------------------
module bto7s
    import seven_seg_pkg::*;
(
    input  logic [3:0] x_in,
    output logic [6:0] s_out
);

    seg_t seg_next;

    always_comb begin
        seg_next = 7'h00;
        unique case (nibble_t'(x_in))
            4'h0: seg_next = 7'h3F;
            4'h1: seg_next = 7'h06;
            4'h2: seg_next = 7'h5B;
            4'h3: seg_next = 7'h4F;
            4'h4: seg_next = 7'h66;
            4'h5: seg_next = 7'h6D;
            4'h6: seg_next = 7'h7D;
            4'h7: seg_next = 7'h07;
            4'h8: seg_next = 7'h7F;
            4'h9: seg_next = 7'h6F;
            4'hA: seg_next = 7'h77;
            4'hB: seg_next = 7'h7C;
            4'hC: seg_next = 7'h39;
            4'hD: seg_next = 7'h5E;
            4'hE: seg_next = 7'h79;
            4'hF: seg_next = 7'h71;
            default: seg_next = 7'h00;
        endcase
    end

    assign s_out = seg_next;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each digit is selected for COUNT_PERIOD cycles; the last BLANK_CYCLES of each
// slot turn every anode off to stop ghosting. Written values are held in a
// shadow register and moved to the displayed register only at the frame
// boundary, so one frame never mixes old and new digits.
//
// Ports
//   clk_in     : system clock
//   rst_in     : synchronous active-high reset
//   val_in     : 32-bit value, digit i = val_in[4i+3:4i]
//   valid_in   : write strobe for val_in
//   lz_en_in   : leading-zero suppression enable (live)
//   blank_in   : force all anodes off (live)
//   cat_out    : cathodes {g,f,e,d,c,b,a}, active-low
//   an_out     : anodes, active-low, bit i selects digit i
//   frame_out  : one-cycle pulse when digit 0 of a new frame is first shown
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int COUNT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 16
)
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] val_in,
    input  logic        valid_in,
    input  logic        lz_en_in,
    input  logic        blank_in,
    output logic [6:0]  cat_out,
    output logic [7:0]  an_out,
    output logic        frame_out
);

    localparam int                CNT_W       = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(COUNT_PERIOD - 1);
    // One extra bit so that BLANK_CYCLES = 0 (start == COUNT_PERIOD) is representable.
    localparam logic [CNT_W:0]    BLANK_START = (CNT_W + 1)'(COUNT_PERIOD - BLANK_CYCLES);

    // State
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    digit_idx_t       idx_reg, idx_next;
    logic [31:0]      shadow_reg, shadow_next;
    logic [31:0]      disp_reg, disp_next;
    logic             pending_reg, pending_next;
    logic             commit_d_reg;

    // Registered outputs
    logic [7:0]       an_reg, an_next;
    seg_t             cat_reg, cat_next;
    logic             frame_reg;

    logic             slot_end;
    logic             commit;
    logic             in_blank;
    logic             lz_hide;
    nibble_t          nibble;
    seg_t             seg;

    // upper_zero[i]: every digit from i upward is zero, so digit i is a
    // leading zero. Digit 0 is always shown, even when the value is 0.
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [NUM_DIGITS-1:0] an_sel;

    assign upper_zero[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_upper_zero
            assign upper_zero[gi] = (disp_reg[NUM_DIGITS*4-1:4*gi] == '0);
        end
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an_sel
            assign an_sel[gi] = (idx_reg != digit_idx_t'(gi));
        end
    endgenerate

    assign slot_end = (cnt_reg == CNT_LAST);
    assign commit   = slot_end && (idx_reg == digit_idx_t'(NUM_DIGITS - 1));
    assign in_blank = ({1'b0, cnt_reg} >= BLANK_START);
    assign lz_hide  = lz_en_in && upper_zero[idx_reg];
    assign nibble   = disp_reg[{idx_reg, 2'b00} +: 4];

    bto7s u_bto7s (
        .x_in  (nibble),
        .s_out (seg)
    );

    always_comb begin
        cnt_next     = slot_end ? '0 : cnt_reg + CNT_W'(1);
        idx_next     = slot_end ? idx_reg + digit_idx_t'(1) : idx_reg;
        shadow_next  = shadow_reg;
        disp_next    = disp_reg;
        pending_next = pending_reg;

        if (commit) begin
            if (valid_in) begin
                // A write landing on the commit cycle goes straight to the display.
                disp_next    = val_in;
                shadow_next  = val_in;
                pending_next = 1'b0;
            end else if (pending_reg) begin
                disp_next    = shadow_reg;
                pending_next = 1'b0;
            end
        end else if (valid_in) begin
            shadow_next  = val_in;
            pending_next = 1'b1;
        end

        an_next  = (blank_in || in_blank || lz_hide) ? 8'hFF : an_sel;
        // Cathodes track the decoded digit even while the anodes are off.
        cat_next = ~seg;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_reg      <= '0;
            idx_reg      <= '0;
            shadow_reg   <= '0;
            disp_reg     <= '0;
            pending_reg  <= 1'b0;
            commit_d_reg <= 1'b0;
            an_reg       <= 8'hFF;
            cat_reg      <= 7'h7F;
            frame_reg    <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            shadow_reg   <= shadow_next;
            disp_reg     <= disp_next;
            pending_reg  <= pending_next;
            an_reg       <= an_next;
            cat_reg      <= cat_next;
            // The commit edge loads digit 0's state; the outputs show it one
            // edge later, so the frame pulse is delayed by one extra stage.
            commit_d_reg <= commit;
            frame_reg    <= commit_d_reg;
        end
    end

    assign an_out    = an_reg;
    assign cat_out   = cat_reg;
    assign frame_out = frame_reg;

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexing controller that drives an 8-digit common-anode seven-segment display from a 32-bit value through a single `bto7s` hex decoder. Steps through the digits at a fixed dwell, blanks all anodes between digits to suppress ghosting, and optionally suppresses leading zeros. New values are double-buffered and take effect only at a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- `COUNT_PERIOD`, default 100000: clock cycles each digit is selected. Must be ≥ 2.
- `BLANK_CYCLES`, default 16: cycles at the end of each digit slot with all anodes off. Must satisfy 0 ≤ BLANK_CYCLES < COUNT_PERIOD.
- `clk_in` input 1: system clock; one clock domain.
- `rst_in` input 1: reset, synchronous, active-high.
- `val_in` input 32: value to display; digit i shows `val_in[4i+3:4i]`.
- `valid_in` input 1: write strobe; captures `val_in` into the shadow register.
- `lz_en_in` input 1: leading-zero suppression enable; sampled live.
- `blank_in` input 1: forces all anodes off; sampled live.
- `cat_out` output 7: cathodes `{g,f,e,d,c,b,a}`, active-low (0 = lit).
- `an_out` output 8: anodes, active-low; bit i selects digit i.
- `frame_out` output 1: single-cycle pulse marking the start of a new frame.

## Operation
State registers:
- `cnt`: 0..COUNT_PERIOD-1.
- `idx`: 3 bits.
- `shadow`: 32 bits.
- `disp`: 32 bits.
- `pending`: 1 bit.

Reset values:
- State: `cnt`=0, `idx`=0, `shadow`=0, `disp`=0, `pending`=0.
- Outputs: `an_out`=8'hFF, `cat_out`=7'h7F, `frame_out`=0.

Counting:
- `cnt` increments every cycle.
- At COUNT_PERIOD-1, `cnt` wraps to 0 and `idx` increments modulo 8.

Commit, on the cycle where `cnt`=COUNT_PERIOD-1 and `idx`=7:
- If `valid_in`=1: `disp` <= `val_in`, `shadow` <= `val_in`, `pending` <= 0. The same-cycle write bypasses into the commit.
- Else if `pending`=1: `disp` <= `shadow`, `pending` <= 0.
- Else: `disp` is unchanged.

Writes:
- `valid_in` on any non-commit cycle sets `shadow` <= `val_in` and `pending` <= 1.
- Repeated writes within a frame overwrite `shadow`; the last one wins.

Digit selection:
- Nibble `disp[4*idx+3:4*idx]` feeds `bto7s`.
- `cat_out` = bitwise NOT of `{sg,sf,se,sd,sc,sb,sa}`.

Anode enable: `an_out[idx]`=0 and all other bits 1, unless any of these holds, in which case `an_out`=8'hFF:
- `blank_in`=1.
- `cnt` ≥ COUNT_PERIOD-BLANK_CYCLES.
- Leading-zero suppression applies: `lz_en_in`=1, `idx`≠0, and `disp[31:4*idx]`==0. Digit 0 is never suppressed.

`cat_out` always reflects the decoded nibble, even when anodes are off.

## Timing
- Outputs are registered and lag the state by exactly 1 cycle.
- Digit slot is COUNT_PERIOD cycles; frame is 8·COUNT_PERIOD cycles.
- First output after reset release: digit 0 with `disp`=0.
  - Cycle 1: `an_out`=8'hFE and `cat_out`=7'h40, provided BLANK_CYCLES < COUNT_PERIOD-0.
- `frame_out`=1 for exactly the one cycle in which `an_out`/`cat_out` first present digit 0 of a new frame, i.e. 1 cycle after the commit edge.
  - No pulse for the frame that starts at reset.
- Write-to-display latency: a write appears no later than the next commit edge + 1 cycle; at most 8·COUNT_PERIOD+1 cycles.
- `rst_in` asserted mid-frame: on the next edge everything returns to reset values; a pending write is discarded.
- `blank_in` and `lz_en_in` take effect on `an_out` 1 cycle after they change.

## Structure
- Package `seven_seg_pkg`:
  - `localparam NUM_DIGITS = 8`.
  - `typedef logic [2:0] digit_idx_t`.
  - `typedef logic [3:0] nibble_t`.
  - `typedef logic [6:0] seg_t`.
- One sub-module: a single instance of the existing `bto7s` decoder. Do not duplicate decode logic.
- Everything else is flat: counter, index, buffering and output registers.

## Test plan
Bench uses COUNT_PERIOD=4, BLANK_CYCLES=1.
- **Reset:** hold `rst_in` 3 cycles, release.
  - `an_out` sequence per slot: FE, FE, FE, FF; next slot FD, FD, FD, FF.
  - `cat_out`=7'h40 throughout.
  - No `frame_out` until cycle 33.
- **Frame-aligned update:** write 32'h89ABCDEF at cycle 5.
  - `disp` is unchanged until the commit edge at cycle 32.
  - From cycle 33: digit 0 `cat_out`=7'h0E ("F"), digit 7 `cat_out`=7'h00 ("8").
  - `frame_out`=1 at cycle 33 only.
- **Commit-cycle bypass and overwrite:** write 32'h1 mid-frame, then 32'h2 on the commit cycle.
  - Digit 0 shows "2" (`cat_out`=7'h24).
  - `pending`=0 afterward.
- **Leading-zero suppression:** `disp`=32'h00000305 with `lz_en_in`=1.
  - Digits 3–7 keep `an_out`=FF.
  - Digits 0–2 are lit, including zero digit 1.
  - With `disp`=0, only digit 0 is lit.
- **Blanking and reset mid-frame:** `blank_in`=1 gives `an_out`=FF on all cycles. Then, with a write pending, assert `rst_in` at slot 5.
  - Next cycle: all reset values.
  - The pending value is never displayed.
